instr_encoder: RTL

Instruction assembler that packs decoded MIPS fields (op, rs, rt, destination, shamt, funct, immediate, jump target) back into 32-bit instruction words. It is the inverse of the datapath's instruction field split, including the RegDst-controlled destination placement. Encoded words are buffered in a small FIFO and presented with a running word address, so a test loader or instruction-memory writer can drain them at its own rate.

---
 rtl/instr_encoder.sv | 86 ++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Packs decoded MIPS fields back into 32-bit instruction words and buffers them
// in a small FIFO, presenting each word with a running word address.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     jump,
  input  logic                     RegDst,
  input  logic [5:0]               op,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  input  logic [4:0]               dst,
  input  logic [4:0]               shamt,
  input  logic [5:0]               funct,
  input  logic [15:0]              imm,
  input  logic [25:0]              target,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [31:0]   word;
  logic          push;
  logic          pop;

  // jump wins over RegDst; I-format drops rt/shamt/funct and puts dst in the rt slot
  always_comb begin
    if (jump)
      word = {op, target};
    else if (RegDst)
      word = {op, rs, rt, dst, shamt, funct};
    else
      word = {op, rs, dst, imm};
  end

  assign in_ready  = (count != FULL) && !flush && !reset;
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush && !reset;
  assign out_instr = out_valid ? mem[head] : 32'h0;

  always_ff @(posedge clock) begin
    if (push)
      mem[tail] <= word;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      out_addr <= '0;
    end else if (flush) begin
      // out_addr keeps running across a flush
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (pop) begin
        head     <= head + 1'b1;
        out_addr <= out_addr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
